rob_wb_arbiter: RTL and testbench
=================================

// Module: rob_wb_arbiter
// PURPOSE
//  Shares the ROB writeback port group (DISPATCH_WIDTH lanes) between NUM_FU functional units.
//  Each FU pushes completion tags {bank_addr, rob_addr} into a private FIFO.
//  A round-robin scheduler drains up to DISPATCH_WIDTH distinct FIFOs per cycle onto robIf.writeback.
//  Sits between the execute-stage FUs and the ROB.
// PARAMETERS
//  NUM_FU          4                 number of requesting functional units (>= DISPATCH_WIDTH)
//  FIFO_DEPTH      4                 per-FU tag FIFO entries (power of 2, >= 2)
//  DISPATCH_WIDTH  (package)         number of writeback lanes
//  ROB_ADDR_WIDTH  (package)         ROB entry address width
// PORTS
//  clk          in   1                            clock
//  rst          in   1                            asynchronous reset, active-high
//  flush        in   1                            pipeline flush: discard all pending tags
//  fu_valid     in   [NUM_FU]                     FU i presents a tag
//  fu_ready     out  [NUM_FU]                     FIFO i accepts a tag this cycle
//  fu_tag       in   wb_tag_t [NUM_FU]            {bank_addr[DISPATCH_WIDTH], rob_addr[ROB_ADDR_WIDTH]}
//  wb           -    robIf.writeback              drives writeback_en/bank_addr/rob_addr per lane
//  stall_cnt    out  [NUM_FU][32]                 per-FU backpressure cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst=1): all FIFOs empty, rr_ptr=0, every writeback_en=0, addr lanes=0,
//   fu_ready=0 while rst is high, stall_cnt=0.
//  Push: on posedge clk, if fu_valid[i] && fu_ready[i], the tag is enqueued to FIFO i.
//   fu_ready[i] = (count_i < FIFO_DEPTH); it depends only on registered count, not on same-cycle pop.
//   A full FIFO does not accept a push even when it pops in the same cycle.
//  Grant: combinational from FIFO heads.
//   Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU, and select the first DISPATCH_WIDTH non-empty FIFOs.
//   The k-th selected FIFO drives lane k: writeback_en[k]=1 with its head tag.
//   Unused lanes have en=0, bank_addr=0, rob_addr=0.
//  Each granted FIFO pops exactly one entry at posedge clk; no FIFO is granted twice per cycle.
//  Latency: a tag pushed at edge t appears on writeback at the earliest in the cycle after t,
//   and is consumed by the ROB at edge t+1.
//  rr_ptr: after any grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
//   With no grant, rr_ptr is unchanged.
//  Per-FU ordering is FIFO; no ordering is guaranteed across FUs.
//  Flush (synchronous):
//   - in the flush cycle all writeback_en=0 and no pop occurs;
//   - at the edge, all FIFOs empty and rr_ptr=0;
//   - a push in the same cycle as flush is dropped, and flush wins.
//   - fu_ready is unaffected in the flush cycle; after the flush, fu_ready=1.
//  Counters: FIFO count width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
//  Reset asserted mid-operation discards all state immediately, with no partial writeback.
// CONFIGURATION
//  ROB_WB_ARB_STATS_EN defined:
//   - stall_cnt[i] increments on each cycle with fu_valid[i] && !fu_ready[i] && !rst;
//   - it saturates at 32'hFFFF_FFFF and clears on rst only (not on flush).
//  ROB_WB_ARB_STATS_EN undefined: stall_cnt tied to 0, no counter flops are generated.
//   The port list is unchanged in both cases.
// STRUCTURE
//  Package parameter: add typedef struct packed wb_tag_t {bank_addr, rob_addr}.
//   DISPATCH_WIDTH and ROB_ADDR_WIDTH come from the package.
//  Sub-module wb_tag_fifo: sync FIFO with clk/rst, flush, push/pop, head, count.
//   It is instantiated NUM_FU times.
//  The grant scan and rr_ptr live in rob_wb_arbiter.
// TESTING (DISPATCH_WIDTH=2, NUM_FU=4, FIFO_DEPTH=4)
//  1. Single push FU1 {bank 1, rob 5} -> next cycle lane0 en=1 bank=1 rob=5, lane1 en=0; rr_ptr becomes 2.
//  2. FU0-3 push one tag each in one cycle, rr_ptr=0 ->
//     cycle+1: lanes carry FU0,FU1 (rr_ptr 2); cycle+2: lanes carry FU2,FU3 (rr_ptr 0); cycle+3: all en=0.
//  3. FU0-3 push every cycle for 10 cycles -> each FU granted every other cycle;
//     a FIFO reaches count 4 and its fu_ready drops to 0; no tag is lost or duplicated (scoreboard).
//  4. FIFOs hold 3 tags each; flush=1 with fu_valid[2]=1 ->
//     flush cycle: all en=0; next cycle: all en=0, fu_ready=4'b1111, FU2's tag absent.
//  5. rst pulsed mid-stream with pending tags ->
//     outputs go to 0 asynchronously; after release, no stale tag appears on any lane.
//  6. With ROB_WB_ARB_STATS_EN: FU0 held full with fu_valid=1 for 5 cycles -> stall_cnt[0]=5;
//     without the macro, stall_cnt stays 0.

Source files
------------

// File: rtl/rob_wb_arbiter_pkg.sv
// rob_wb_arbiter_pkg: shared widths and the writeback completion tag type.
package rob_wb_arbiter_pkg;

    localparam int DISPATCH_WIDTH = 2;
    localparam int ROB_ADDR_WIDTH = 6;

    typedef struct packed {
        logic [DISPATCH_WIDTH-1:0] bank_addr;
        logic [ROB_ADDR_WIDTH-1:0] rob_addr;
    } wb_tag_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// wb_tag_fifo: per-FU completion tag FIFO with synchronous flush.
module wb_tag_fifo
    import rob_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  wb_tag_t                 i_tag,
    output wb_tag_t                 o_head,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_tag_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    // Flush beats both push and pop; a full FIFO never accepts, even while popping.
    assign w_push = i_push && !i_flush && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_tag;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: round-robin drain of per-FU tag FIFOs onto the ROB writeback lanes.
// Optional stall counters are built when ROB_WB_ARB_STATS_EN is defined.
module rob_wb_arbiter
    import rob_wb_arbiter_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            flush,
    input  logic [NUM_FU-1:0]                               fu_valid,
    output logic [NUM_FU-1:0]                               fu_ready,
    input  wb_tag_t [NUM_FU-1:0]                            fu_tag,
    output logic [DISPATCH_WIDTH-1:0]                       wb_writeback_en,
    output logic [DISPATCH_WIDTH-1:0][DISPATCH_WIDTH-1:0]   wb_bank_addr,
    output logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]   wb_rob_addr,
    output logic [NUM_FU-1:0][31:0]                         stall_cnt
);
    localparam int FW = idx_width(NUM_FU);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int KW = $clog2(DISPATCH_WIDTH + 1);

    wb_tag_t            w_head  [NUM_FU];
    logic [CW-1:0]      w_count [NUM_FU];
    logic [NUM_FU-1:0]  w_grant;
    logic [FW-1:0]      r_rr;
    logic [FW-1:0]      w_next_rr;
    logic [FW-1:0]      w_idx;
    logic [KW-1:0]      w_lane;

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fifo
        wb_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush),
            .i_push  (fu_valid[f] && fu_ready[f]),
            .i_pop   (w_grant[f]),
            .i_tag   (fu_tag[f]),
            .o_head  (w_head[f]),
            .o_count (w_count[f])
        );
        assign fu_ready[f] = !rst && (w_count[f] < CW'(FIFO_DEPTH));
    end

    // Scan from r_rr; the k-th non-empty FIFO found owns lane k.
    always_comb begin
        w_grant         = '0;
        wb_writeback_en = '0;
        wb_bank_addr    = '0;
        wb_rob_addr     = '0;
        w_next_rr       = r_rr;
        w_lane          = '0;
        w_idx           = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            w_idx = FW'((int'(r_rr) + j) % NUM_FU);
            if (!flush && (w_count[w_idx] != '0) && (int'(w_lane) < DISPATCH_WIDTH)) begin
                w_grant[w_idx] = 1'b1;
                for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                    if (int'(w_lane) == l) begin
                        wb_writeback_en[l] = 1'b1;
                        wb_bank_addr[l]    = w_head[w_idx].bank_addr;
                        wb_rob_addr[l]     = w_head[w_idx].rob_addr;
                    end
                end
                w_lane    = w_lane + 1'b1;
                w_next_rr = FW'((int'(w_idx) + 1) % NUM_FU);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rr <= '0;
        else r_rr <= flush ? '0 : w_next_rr;
    end

`ifdef ROB_WB_ARB_STATS_EN
    logic [NUM_FU-1:0][31:0] r_stall;

    // Saturating; deliberately survives flush so stalls accumulate across pipeline restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && !fu_ready[i] && (r_stall[i] != '1)) r_stall[i] <= r_stall[i] + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb_rob_wb_arbiter: directed vector table, flush/reset corner sequences and a
// randomized run against a queue-based model of the writeback arbiter.
module tb_rob_wb_arbiter;
    import rob_wb_arbiter_pkg::*;

    localparam int NF    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = DISPATCH_WIDTH;
    localparam int RW    = ROB_ADDR_WIDTH;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       flush = 1'b0;
    logic [NF-1:0]              fu_valid = '0;
    logic [NF-1:0]              fu_ready;
    wb_tag_t [NF-1:0]           fu_tag = '0;
    logic [DW-1:0]              wb_en;
    logic [DW-1:0][DW-1:0]      wb_bank;
    logic [DW-1:0][RW-1:0]      wb_rob;
    logic [NF-1:0][31:0]        stall_cnt;

    always #5 clk = ~clk;

    rob_wb_arbiter #(.NUM_FU(NF), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .fu_valid        (fu_valid),
        .fu_ready        (fu_ready),
        .fu_tag          (fu_tag),
        .wb_writeback_en (wb_en),
        .wb_bank_addr    (wb_bank),
        .wb_rob_addr     (wb_rob),
        .stall_cnt       (stall_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per FU, a scan pointer and stall tallies.
    wb_tag_t                mq [NF][$];
    int                     mrr;
    int                     mstall [NF];
    logic [DW-1:0]          m_en;
    logic [DW-1:0][DW-1:0]  m_bank;
    logic [DW-1:0][RW-1:0]  m_rob;
    logic [NF-1:0]          m_grant;
    logic [NF-1:0]          m_ready;
    int                     m_last;

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            mq[i].delete();
            mstall[i] = 0;
        end
        mrr = 0;
    endtask

    task automatic model_eval();
        int n;
        n = 0;
        m_en = '0;
        m_bank = '0;
        m_rob = '0;
        m_grant = '0;
        m_last = -1;
        for (int i = 0; i < NF; i++) m_ready[i] = (mq[i].size() < DEPTH);
        if (!flush) begin
            for (int j = 0; j < NF; j++) begin
                int f;
                f = (mrr + j) % NF;
                if (mq[f].size() > 0 && n < DW) begin
                    m_grant[f] = 1'b1;
                    m_en[n] = 1'b1;
                    m_bank[n] = mq[f][0].bank_addr;
                    m_rob[n] = mq[f][0].rob_addr;
                    m_last = f;
                    n++;
                end
            end
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < NF; i++) if (fu_valid[i] && !m_ready[i]) mstall[i]++;
        if (flush) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            mrr = 0;
        end else begin
            for (int i = 0; i < NF; i++) if (m_grant[i]) void'(mq[i].pop_front());
            if (m_last >= 0) mrr = (m_last + 1) % NF;
            for (int i = 0; i < NF; i++) if (fu_valid[i] && m_ready[i]) mq[i].push_back(fu_tag[i]);
        end
    endtask

    task automatic compare_model();
        chk("wb_en", 64'(wb_en), 64'(m_en));
        for (int l = 0; l < DW; l++) begin
            chk($sformatf("lane%0d_bank", l), 64'(wb_bank[l]), 64'(m_bank[l]));
            chk($sformatf("lane%0d_rob", l), 64'(wb_rob[l]), 64'(m_rob[l]));
        end
        chk("fu_ready", 64'(fu_ready), 64'(m_ready));
        for (int i = 0; i < NF; i++) begin
`ifdef ROB_WB_ARB_STATS_EN
            chk($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i]), 64'(mstall[i]));
`else
            chk($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i]), 64'd0);
`endif
        end
    endtask

    // Inputs change only just after negedge; the model advances with the DUT at posedge.
    task automatic tick(input bit use_model);
        #1;
        model_eval();
        if (use_model) compare_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NF-1:0] v, input logic f, input logic [RW-1:0] base);
        fu_valid = v;
        flush = f;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i].bank_addr = DW'(i);
            fu_tag[i].rob_addr = base + RW'(i);
        end
    endtask

    typedef struct {
        logic [NF-1:0] valid;
        logic          flush;
        logic [RW-1:0] base;
        logic [DW-1:0] en;
        logic [DW-1:0] b0;
        logic [RW-1:0] r0;
        logic [DW-1:0] b1;
        logic [RW-1:0] r1;
    } vec_t;

    vec_t tbl [14];
    logic saw_full;

    initial begin
        // FU i always presents {bank i, rob base+i} in the table rows.
        tbl[0]  = '{4'b0010, 1'b0, 6'd4,  2'b00, 2'd0, 6'd0,  2'd0, 6'd0};
        tbl[1]  = '{4'b0000, 1'b0, 6'd0,  2'b01, 2'd1, 6'd5,  2'd0, 6'd0};
        tbl[2]  = '{4'b0101, 1'b0, 6'd50, 2'b00, 2'd0, 6'd0,  2'd0, 6'd0};
        tbl[3]  = '{4'b0000, 1'b0, 6'd0,  2'b11, 2'd2, 6'd52, 2'd0, 6'd50};
        tbl[4]  = '{4'b0000, 1'b1, 6'd0,  2'b00, 2'd0, 6'd0,  2'd0, 6'd0};
        tbl[5]  = '{4'b1111, 1'b0, 6'd10, 2'b00, 2'd0, 6'd0,  2'd0, 6'd0};
        tbl[6]  = '{4'b0000, 1'b0, 6'd0,  2'b11, 2'd0, 6'd10, 2'd1, 6'd11};
        tbl[7]  = '{4'b0000, 1'b0, 6'd0,  2'b11, 2'd2, 6'd12, 2'd3, 6'd13};
        tbl[8]  = '{4'b0000, 1'b0, 6'd0,  2'b00, 2'd0, 6'd0,  2'd0, 6'd0};
        tbl[9]  = '{4'b1001, 1'b0, 6'd20, 2'b00, 2'd0, 6'd0,  2'd0, 6'd0};
        tbl[10] = '{4'b0000, 1'b0, 6'd0,  2'b11, 2'd0, 6'd20, 2'd3, 6'd23};
        tbl[11] = '{4'b0110, 1'b0, 6'd30, 2'b00, 2'd0, 6'd0,  2'd0, 6'd0};
        tbl[12] = '{4'b0001, 1'b0, 6'd40, 2'b11, 2'd1, 6'd31, 2'd2, 6'd32};
        tbl[13] = '{4'b0000, 1'b0, 6'd0,  2'b01, 2'd0, 6'd40, 2'd0, 6'd0};

        model_reset();
        @(negedge clk);
        chk("reset_en", 64'(wb_en), 64'd0);
        chk("reset_bank", 64'(wb_bank), 64'd0);
        chk("reset_rob", 64'(wb_rob), 64'd0);
        chk("reset_ready", 64'(fu_ready), 64'd0);
        for (int i = 0; i < NF; i++) chk($sformatf("reset_stall%0d", i), 64'(stall_cnt[i]), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 14; k++) begin
            drive(tbl[k].valid, tbl[k].flush, tbl[k].base);
            #1;
            chk($sformatf("tbl%0d_en", k), 64'(wb_en), 64'(tbl[k].en));
            chk($sformatf("tbl%0d_bank0", k), 64'(wb_bank[0]), 64'(tbl[k].b0));
            chk($sformatf("tbl%0d_rob0", k), 64'(wb_rob[0]), 64'(tbl[k].r0));
            chk($sformatf("tbl%0d_bank1", k), 64'(wb_bank[1]), 64'(tbl[k].b1));
            chk($sformatf("tbl%0d_rob1", k), 64'(wb_rob[1]), 64'(tbl[k].r1));
            chk($sformatf("tbl%0d_ready", k), 64'(fu_ready), 64'hF);
            tick(0);
        end

        // All FUs push every cycle: backpressure must appear, nothing lost.
        saw_full = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(4'hF, 1'b0, RW'(k * 4));
            tick(1);
            saw_full |= ~&fu_ready;
        end
        chk("burst_ready_dropped", 64'(saw_full), 64'd1);
        for (int k = 0; k < 10; k++) begin
            drive(4'h0, 1'b0, '0);
            tick(1);
        end
        chk("burst_drained_en", 64'(wb_en), 64'd0);

        // Flush with pending tags and a same-cycle push from FU2.
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, 1'b0, RW'(8 + k * 4));
            tick(1);
        end
        drive(4'b0100, 1'b1, 6'd60);
        #1;
        chk("flush_cycle_en", 64'(wb_en), 64'd0);
        tick(1);
        drive(4'h0, 1'b0, '0);
        #1;
        chk("post_flush_en", 64'(wb_en), 64'd0);
        chk("post_flush_ready", 64'(fu_ready), 64'hF);
        tick(1);
        tick(1);

        // Asynchronous reset in the middle of traffic.
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, 1'b0, RW'(16 + k * 4));
            tick(1);
        end
        drive(4'h0, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_en", 64'(wb_en), 64'd0);
        chk("async_rst_ready", 64'(fu_ready), 64'd0);
        @(negedge clk);
        for (int i = 0; i < NF; i++) chk($sformatf("async_rst_stall%0d", i), 64'(stall_cnt[i]), 64'd0);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) tick(1);

        // Randomized traffic with heavy valid density and occasional flushes.
        for (int k = 0; k < 400; k++) begin
            fu_valid = NF'($urandom | $urandom);
            flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NF; i++) begin
                fu_tag[i].bank_addr = DW'($urandom);
                fu_tag[i].rob_addr = RW'($urandom);
            end
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
